instr_fetch: RTL

- Fetch-side initiator for the word-addressed instruction memory.
- Drives the memory address, captures the returned word and tags it with its PC.
- Buffers fetched words in a 2-entry queue and presents them to decode with a valid/ready handshake.
- Handles branch redirect/flush, enable-stall and out-of-range fault; sits between the instruction memory and the decode stage.

---
 rtl/instr_fetch.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word addresses to instruction memory and hands the
// returned words, tagged with their PC, to decode through a 2-entry FIFO.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int unsigned DEPTH    = 1024
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Enable,
    output logic [31:0] MemAddr,
    input  logic [31:0] MemQ,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic        Fault
);
    localparam logic [31:0] Limit = 32'(DEPTH);

    typedef enum logic [1:0] {StRun, StHalt, StFault} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        inf_q, inf_d;
    logic [31:0] inf_pc_q, inf_pc_d;
    logic [31:0] inf_word_q, inf_word_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] head_word_q, head_word_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic [31:0] tail_word_q, tail_word_d;
    logic [31:0] tail_pc_q, tail_pc_d;
    logic        fault_q, fault_d;

    logic       redirect, pop, push, want_issue, out_of_range, issue;
    logic [2:0] credit;

    always_comb begin
        redirect     = BranchTaken && (state_q != StFault);
        pop          = (count_q != 2'd0) && InstrReady;
        push         = inf_q && !redirect;
        credit       = {1'b0, count_q} - {2'b00, pop} + {2'b00, inf_q};
        want_issue   = (state_q == StRun) && Enable && !BranchTaken && (credit < 3'd2);
        out_of_range = pc_q >= Limit;
        issue        = want_issue && !out_of_range;

        state_d     = state_q;
        pc_d        = pc_q;
        inf_d       = issue;
        inf_pc_d    = inf_pc_q;
        inf_word_d  = inf_word_q;
        count_d     = count_q;
        head_word_d = head_word_q;
        head_pc_d   = head_pc_q;
        tail_word_d = tail_word_q;
        tail_pc_d   = tail_pc_q;
        fault_d     = fault_q;

        // MemAddr has been stable since the previous edge, so MemQ already holds
        // the word for pc_q; latch it now and enqueue it on the next edge.
        if (issue) begin
            inf_pc_d   = pc_q;
            inf_word_d = MemQ;
            pc_d       = pc_q + 32'd1;
        end

        if (redirect) begin
            pc_d    = BranchTarget;
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_word_d = inf_word_q;
                        head_pc_d   = inf_pc_q;
                    end else begin
                        tail_word_d = inf_word_q;
                        tail_pc_d   = inf_pc_q;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_word_d = tail_word_q;
                    head_pc_d   = tail_pc_q;
                    count_d     = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_word_d = inf_word_q;
                        head_pc_d   = inf_pc_q;
                    end else begin
                        head_word_d = tail_word_q;
                        head_pc_d   = tail_pc_q;
                        tail_word_d = inf_word_q;
                        tail_pc_d   = inf_pc_q;
                    end
                end
                default: ;
            endcase
        end

        case (state_q)
            StRun, StHalt: begin
                if (want_issue && out_of_range) begin
                    state_d = StFault;
                    fault_d = 1'b1;
                end else begin
                    state_d = Enable ? StRun : StHalt;
                end
            end
            StFault: ;
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= StRun;
            pc_q        <= RESET_PC;
            inf_q       <= 1'b0;
            inf_pc_q    <= 32'd0;
            inf_word_q  <= 32'd0;
            count_q     <= 2'd0;
            head_word_q <= 32'd0;
            head_pc_q   <= 32'd0;
            tail_word_q <= 32'd0;
            tail_pc_q   <= 32'd0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inf_q       <= inf_d;
            inf_pc_q    <= inf_pc_d;
            inf_word_q  <= inf_word_d;
            count_q     <= count_d;
            head_word_q <= head_word_d;
            head_pc_q   <= head_pc_d;
            tail_word_q <= tail_word_d;
            tail_pc_q   <= tail_pc_d;
            fault_q     <= fault_d;
        end
    end

    assign MemAddr    = pc_q;
    assign InstrValid = count_q != 2'd0;
    assign Instr      = head_word_q;
    assign InstrPC    = head_pc_q;
    assign Fault      = fault_q;
endmodule
